program_loader: RTL and testbench

- Loads a program image into the datapath's instruction memory before execution. Observing the register file only reads state out; this block drives it in.
- Accepts a byte stream over a valid/ready handshake: one length header byte, then N little-endian 32-bit instruction words.
- Issues one memory write per assembled word.
- Holds the datapath in reset (cpuHold) until the image has loaded.

---
 rtl/program_loader.sv | 152 +++++++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program image loader that writes 32-bit words into instruction memory
// Holds the datapath in reset until a header-counted, little-endian word image has been written.
module program_loader #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int MAX_WORDS     = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               byteIn,
    input  logic                     byteValid,
    output logic                     byteReady,
    output logic                     memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    output logic [31:0]              memWriteData,
    output logic                     cpuHold,
    output logic                     done,
    output logic                     error,
    output logic [7:0]               wordCount
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned MAX_N = MAX_WORDS;

    state_t                   state_q, state_d;
    logic [1:0]               lane_q, lane_d;
    logic [23:0]              asm_q, asm_d;
    logic [7:0]               n_words_q, n_words_d;
    logic [7:0]               word_count_q, word_count_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]              mem_data_q, mem_data_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     ready;
    logic                     accept;

    assign ready  = (state_q == HEADER) || (state_q == LOAD);
    assign accept = ready && byteValid;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        n_words_d    = n_words_q;
        word_count_d = word_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            HEADER: begin
                if (accept) begin
                    if (byteIn == 8'd0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (32'(byteIn) > MAX_N) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        n_words_d = byteIn;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    case (lane_q)
                        2'd0: asm_d[7:0]   = byteIn;
                        2'd1: asm_d[15:8]  = byteIn;
                        2'd2: asm_d[23:16] = byteIn;
                        default: begin
                            mem_we_d     = 1'b1;
                            mem_data_d   = {byteIn, asm_q};
                            mem_addr_d   = ADDRESS_WIDTH'({word_count_q, 2'b00});
                            word_count_d = word_count_q + 8'd1;
                            // The final strobe cycle already sits in DONE; done/cpuHold follow a cycle later.
                            if (word_count_q + 8'd1 == n_words_q) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
            end
            default: begin
                if (start) begin
                    state_d      = HEADER;
                    word_count_d = 8'd0;
                    lane_d       = 2'd0;
                    mem_addr_d   = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    cpu_hold_d   = 1'b1;
                end else if (state_q == DONE) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= 2'd0;
            asm_q        <= 24'd0;
            n_words_q    <= 8'd0;
            word_count_q <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 32'd0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            n_words_q    <= n_words_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byteReady      = ready;
    assign memWriteEnable = mem_we_q;
    assign memAddress     = mem_addr_q;
    assign memWriteData   = mem_data_q;
    assign cpuHold        = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign wordCount      = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byteIn = 8'd0;
    logic        byteValid = 1'b0;
    logic        byteReady;
    logic        memWriteEnable;
    logic [9:0]  memAddress;
    logic [31:0] memWriteData;
    logic        cpuHold;
    logic        done;
    logic        error;
    logic [7:0]  wordCount;

    program_loader #(.ADDRESS_WIDTH(10), .MAX_WORDS(64)) dut (
        .clock(clock), .reset(reset), .start(start), .byteIn(byteIn),
        .byteValid(byteValid), .byteReady(byteReady),
        .memWriteEnable(memWriteEnable), .memAddress(memAddress),
        .memWriteData(memWriteData), .cpuHold(cpuHold), .done(done),
        .error(error), .wordCount(wordCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    logic [9:0]  s_addr[$];
    logic [31:0] s_data[$];
    int          s_cyc[$];
    int          wide_cnt = 0;
    logic        prev_we = 1'b0;

    always @(negedge clock) begin
        if (memWriteEnable) begin
            s_addr.push_back(memAddress);
            s_data.push_back(memWriteData);
            s_cyc.push_back(cyc);
            if (prev_we) wide_cnt = wide_cnt + 1;
        end
        prev_we = memWriteEnable;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        s_addr.delete();
        s_data.delete();
        s_cyc.delete();
        wide_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byteIn = b;
        byteValid = 1'b1;
        while (!byteReady && n < 20) begin
            tick();
            n++;
        end
        if (!byteReady) chk("send_ready_timeout", 32'(byteReady), 32'd1);
        tick();
        byteValid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byteReady), 32'd0);
        chk({tag, "_we"}, 32'(memWriteEnable), 32'd0);
        chk({tag, "_addr"}, 32'(memAddress), 32'd0);
        chk({tag, "_data"}, memWriteData, 32'd0);
        chk({tag, "_hold"}, 32'(cpuHold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_wc"}, 32'(wordCount), 32'd0);
    endtask

    typedef struct {
        logic        st;
        logic        bv;
        logic [7:0]  b;
        logic        ready;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        hold;
        logic        dn;
        logic [7:0]  wc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'h50, 1'b1, 1'b0, 10'h000, 32'h00000000, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 10'h000, 32'h00500013, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 8'h93, 1'b1, 1'b0, 10'h000, 32'h00500013, 1'b1, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'h000, 32'h00500013, 1'b1, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 10'h000, 32'h00500013, 1'b1, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 10'h004, 32'h00100093, 1'b1, 1'b0, 8'd2};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h004, 32'h00100093, 1'b0, 1'b1, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h004, 32'h00100093, 1'b0, 1'b1, 8'd2};

        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("reset");

        for (int i = 0; i < 12; i++) begin
            start = vecs[i].st;
            byteValid = vecs[i].bv;
            byteIn = vecs[i].b;
            tick();
            chk($sformatf("v%0d_ready", i), 32'(byteReady), 32'(vecs[i].ready));
            chk($sformatf("v%0d_we", i), 32'(memWriteEnable), 32'(vecs[i].we));
            chk($sformatf("v%0d_addr", i), 32'(memAddress), 32'(vecs[i].addr));
            chk($sformatf("v%0d_data", i), memWriteData, vecs[i].data);
            chk($sformatf("v%0d_hold", i), 32'(cpuHold), 32'(vecs[i].hold));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_wc", i), 32'(wordCount), 32'(vecs[i].wc));
        end
        start = 1'b0;
        byteValid = 1'b0;

        // Reload from DONE with a stalling stream.
        clear_mon();
        pulse_start();
        chk("reload_hold", 32'(cpuHold), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        begin
            logic [7:0] bytes[9];
            bytes = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
            for (int i = 0; i < 9; i++) begin
                send(bytes[i]);
                tick();
            end
        end
        chk("gap_strobes", 32'(s_addr.size()), 32'd2);
        if (s_addr.size() == 2) begin
            chk("gap_addr0", 32'(s_addr[0]), 32'h000);
            chk("gap_data0", s_data[0], 32'h00500013);
            chk("gap_addr1", 32'(s_addr[1]), 32'h004);
            chk("gap_data1", s_data[1], 32'h00100093);
            chk("gap_spacing", 32'(s_cyc[1] - s_cyc[0]), 32'd8);
        end
        chk("gap_width", 32'(wide_cnt), 32'd0);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_hold", 32'(cpuHold), 32'd0);
        chk("gap_wc", 32'(wordCount), 32'd2);

        // Zero-length header.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_mon();
        pulse_start();
        send(8'h00);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hold", 32'(cpuHold), 32'd0);
        chk("zero_wc", 32'(wordCount), 32'd0);
        tick();
        chk("zero_strobes", 32'(s_addr.size()), 32'd0);

        // Oversized header, then recovery.
        pulse_start();
        send(8'h41);
        chk("err_error", 32'(error), 32'd1);
        chk("err_hold", 32'(cpuHold), 32'd1);
        chk("err_ready", 32'(byteReady), 32'd0);
        chk("err_done", 32'(done), 32'd0);
        tick();
        chk("err_strobes", 32'(s_addr.size()), 32'd0);
        pulse_start();
        chk("rec_error", 32'(error), 32'd0);
        send(8'h01);
        send(8'hEF);
        send(8'hBE);
        send(8'hAD);
        send(8'hDE);
        tick();
        chk("rec_strobes", 32'(s_addr.size()), 32'd1);
        if (s_addr.size() == 1) begin
            chk("rec_addr", 32'(s_addr[0]), 32'h000);
            chk("rec_data", s_data[0], 32'hDEADBEEF);
        end
        chk("rec_done", 32'(done), 32'd1);

        // Asynchronous reset in the middle of a 3-word load.
        clear_mon();
        pulse_start();
        send(8'h03);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        send(8'h66);
        chk("mid_wc", 32'(wordCount), 32'd1);
        chk("mid_data", memWriteData, 32'h44332211);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("async_strobes", 32'(s_addr.size()), 32'd1);
        clear_mon();
        pulse_start();
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        tick();
        chk("post_strobes", 32'(s_addr.size()), 32'd1);
        if (s_addr.size() == 1) begin
            chk("post_addr", 32'(s_addr[0]), 32'h000);
            chk("post_data", s_data[0], 32'hDDCCBBAA);
        end
        chk("post_done", 32'(done), 32'd1);
        chk("post_hold", 32'(cpuHold), 32'd0);

        // Reload from a settled DONE.
        clear_mon();
        pulse_start();
        chk("rl_hold", 32'(cpuHold), 32'd1);
        chk("rl_done", 32'(done), 32'd0);
        send(8'h01);
        send(8'h78);
        send(8'h56);
        send(8'h34);
        chk("rl_hold_during", 32'(cpuHold), 32'd1);
        send(8'h12);
        chk("rl_we", 32'(memWriteEnable), 32'd1);
        chk("rl_strobe_done", 32'(done), 32'd0);
        tick();
        chk("rl_strobes", 32'(s_addr.size()), 32'd1);
        if (s_addr.size() == 1) begin
            chk("rl_addr", 32'(s_addr[0]), 32'h000);
            chk("rl_data", s_data[0], 32'h12345678);
        end
        chk("rl_done_after", 32'(done), 32'd1);
        chk("rl_hold_after", 32'(cpuHold), 32'd0);
        chk("rl_wc", 32'(wordCount), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
